micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter: ADDR_W, 11, microcode address width.
REQ-002 SHALL have parameter: STACK_DEPTH, 4, return-stack entries (>=1).
REQ-003 SHALL have parameter: COND_W, 8, number of condition inputs (power of 2).
REQ-004 SHALL have parameter: CNT_W, 8, loop-counter width (<=ADDR_W).
REQ-005 SHALL have port: clock  in  1  rising-edge clock.
REQ-006 SHALL have port: reset  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port: op  in  4  sequencer opcode from the microword pipeline register.
REQ-008 SHALL have port: branch_addr  in  ADDR_W  branch target or counter load value.
REQ-009 SHALL have port: case_bits  in  4  OR-in bits for CASE dispatch.
REQ-010 SHALL have port: cond_in  in  COND_W  condition sources (flags, mode bits).
REQ-011 SHALL have port: cond_sel  in  log2(COND_W)  condition select.
REQ-012 SHALL have port: cond_pol  in  1  1 inverts the selected condition.
REQ-013 SHALL have port: hold  in  1  freeze sequencing for one cycle (wait state).
REQ-014 SHALL have port: uaddr  out  ADDR_W  combinational next address to the microcode ROM.
REQ-015 SHALL have port: stack_ovf, stack_unf  out  1 each  sticky stack-error flags.
REQ-016 SHALL have port: cnt_zero  out  1  loop counter equals 0.

Function
REQ-017 SHALL hold addr_q (last issued address) and define uPC = addr_q+1, modulo 2^ADDR_W.
REQ-018 SHALL define cond = cond_in[cond_sel] XOR cond_pol.
REQ-019 SHALL drive uaddr and update state per op:
- 0 CONT: uPC.
- 1 JMP: branch_addr.
- 2 CJMP: branch_addr if cond, else uPC.
- 3 CALL: push uPC; branch_addr.
- 4 CCALL: if cond, as CALL; else uPC, no push.
- 5 RET: pop; popped value.
- 6 CRET: if cond, as RET; else uPC, no pop.
- 7 LDCNT: counter <= branch_addr[CNT_W-1:0]; uPC.
- 8 LOOP: if counter!=0, decrement and branch_addr; else uPC.
- 9 CASE: {branch_addr[ADDR_W-1:4], branch_addr[3:0] | case_bits}.
- 10 PUSH: push uPC; uPC (loop head marker).
- 11 RPT: if counter!=0, decrement and top-of-stack, no pop; else pop, uPC.
- 12-15: as CONT.
REQ-020 SHALL register addr_q <= uaddr on every non-hold rising edge; latency from op to ROM address SHALL be zero (combinational).
REQ-021 SHALL, with hold=1, drive uaddr = addr_q and leave addr_q, stack, counter and flags unchanged.
REQ-022 SHALL, on push when full (STACK_DEPTH entries), drop the write, keep the depth, set stack_ovf, and still take the branch.
REQ-023 SHALL, on pop when empty (RET, taken CRET, RPT exit), drive uaddr = uPC, set stack_unf, and keep depth at 0.
REQ-024 SHALL, on RPT with counter!=0 and empty stack, drive uPC, set stack_unf and decrement the counter.
REQ-025 SHALL hold the counter at 0 on LOOP/RPT at 0 (no wrap to all-ones).
REQ-026 SHALL drive cnt_zero combinationally from the counter register.

Reset
REQ-027 SHALL, while reset=1, force uaddr=0, addr_q=0, stack depth=0, counter=0, stack_ovf=0, stack_unf=0, cnt_zero=1.
REQ-028 SHALL issue address 0 in the first cycle after reset release and address 1 on the following edge if op=CONT.
REQ-029 SHALL abandon any in-progress loop or call nesting when reset is asserted mid-operation; stack contents SHALL be unspecified, but depth SHALL be 0.

Structure
REQ-030 SHALL place op encodings (OP_CONT..OP_RPT) and the op width constant in shared package micro_seq_pkg.
REQ-031 SHALL implement the LIFO as sub-module micro_stack (parameters ADDR_W, STACK_DEPTH; push, pop, top, full, empty).

Verification
REQ-032 SHALL cover: reset, release, op=CONT x3 -> uaddr 0,1,2,3.
REQ-033 SHALL cover: addr_q=0x010, CALL 0x200, CONT, RET -> uaddr 0x200, 0x201, 0x011; stack empty after.
REQ-034 SHALL cover: LDCNT 3, then LOOP 0x040 at 0x040 -> three taken branches, then fall-through to 0x041 with cnt_zero=1.
REQ-035 SHALL cover: CASE branch_addr=0x120, case_bits=0x5 -> uaddr 0x125; CJMP with cond_in[2]=1, cond_sel=2, cond_pol=1 -> not taken.
REQ-036 SHALL cover: five CALLs with STACK_DEPTH=4 -> stack_ovf=1 after the fifth; five RETs -> four correct returns, fifth gives uPC and stack_unf=1.
REQ-037 SHALL cover: hold=1 during a CALL for 2 cycles -> uaddr constant and depth unchanged; CALL takes effect on hold release.

Source files
------------

// File: rtl/micro_seq_pkg.sv
// rtl/micro_seq_pkg.sv - shared opcode encodings for the micro sequencer
//
// Purpose: single home for the sequencer opcode width and encodings so the
//          sequencer, its bus interface and any microcode tooling agree.
// Ports:   none (package).

package micro_seq_pkg;

    localparam int OP_W = 4;

    // Encodings 12..15 are reserved and decode as OP_CONT.
    typedef enum logic [OP_W-1:0] {
        OP_CONT  = 4'd0,
        OP_JMP   = 4'd1,
        OP_CJMP  = 4'd2,
        OP_CALL  = 4'd3,
        OP_CCALL = 4'd4,
        OP_RET   = 4'd5,
        OP_CRET  = 4'd6,
        OP_LDCNT = 4'd7,
        OP_LOOP  = 4'd8,
        OP_CASE  = 4'd9,
        OP_PUSH  = 4'd10,
        OP_RPT   = 4'd11
    } op_e;

endpackage

// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - microword-to-sequencer bus with master/slave views
//
// Purpose: bundles the fields the microword pipeline register presents to the
//          sequencer together with the sequencer's address and status outputs.
// Ports:   master - microword side: drives op, branch_addr, case_bits,
//                   cond_in, cond_sel, cond_pol, hold; reads uaddr,
//                   stack_ovf, stack_unf, cnt_zero.
//          slave  - sequencer side: the mirror image of master.

interface micro_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int COND_W = 8
) ();
    import micro_seq_pkg::*;

    localparam int SEL_W = (COND_W > 1) ? $clog2(COND_W) : 1;

    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] branch_addr;
    logic [3:0]        case_bits;
    logic [COND_W-1:0] cond_in;
    logic [SEL_W-1:0]  cond_sel;
    logic              cond_pol;
    logic              hold;
    logic [ADDR_W-1:0] uaddr;
    logic              stack_ovf;
    logic              stack_unf;
    logic              cnt_zero;

    modport master (
        output op, branch_addr, case_bits, cond_in, cond_sel, cond_pol, hold,
        input  uaddr, stack_ovf, stack_unf, cnt_zero
    );

    modport slave (
        input  op, branch_addr, case_bits, cond_in, cond_sel, cond_pol, hold,
        output uaddr, stack_ovf, stack_unf, cnt_zero
    );

endinterface

// File: rtl/micro_stack.sv
// rtl/micro_stack.sv - return-address LIFO for the micro sequencer
//
// Purpose: STACK_DEPTH-entry LIFO. A push when full and a pop when empty are
//          ignored; the caller is responsible for flagging them.
// Ports:   clock, reset (async, active-high) - clocking; reset empties the stack
//          push_i, data_i                    - push data_i on the rising edge
//          pop_i                             - discard the top entry
//          top_o                             - current top entry (invalid when empty)
//          full_o, empty_o                   - occupancy status

module micro_stack #(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(STACK_DEPTH);

    logic [PTR_W-1:0]  depth_q, depth_d;
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  top_idx;

    assign full_o  = (depth_q == PTR_FULL);
    assign empty_o = (depth_q == '0);
    assign wr_en   = push_i && !full_o;
    assign wr_idx  = IDX_W'(depth_q);
    assign top_idx = IDX_W'(depth_q - PTR_ONE);
    assign top_o   = mem_q[top_idx];

    always_comb begin
        depth_d = depth_q;
        if (wr_en) begin
            depth_d = depth_q + PTR_ONE;
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - PTR_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // Entry contents need no reset: an empty stack is never read as valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram address sequencer
//
// Purpose: computes the next microcode ROM address combinationally from the
//          current microword's sequencer op, with call/return stack, loop
//          counter, condition test and CASE dispatch.
// Ports:   clock, reset (async, active-high)
//          bus (slave) - op, branch_addr, case_bits, cond_in, cond_sel,
//                        cond_pol, hold in; uaddr, stack_ovf, stack_unf,
//                        cnt_zero out.

module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4,
    parameter int COND_W      = 8,
    parameter int CNT_W       = 8
) (
    input  logic               clock,
    input  logic               reset,
    micro_sequencer_if.slave   bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_q, start_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] upc;
    logic [ADDR_W-1:0] uaddr_d;
    logic              cond;
    logic              cnt_nz;
    logic              push, pop;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full, stk_empty;

    micro_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (upc),
        .top_o   (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign upc    = addr_q + ADDR_ONE;
    assign cond   = bus.cond_in[bus.cond_sel] ^ bus.cond_pol;
    assign cnt_nz = (cnt_q != '0);

    always_comb begin
        uaddr_d = upc;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;

        if (reset) begin
            uaddr_d = '0;
        end else if (bus.hold) begin
            uaddr_d = addr_q;
        end else if (start_q) begin
            // First cycle out of reset: nothing valid has been fetched yet,
            // so the pipeline op is ignored and address 0 is issued.
            uaddr_d = '0;
            start_d = 1'b0;
        end else begin
            case (bus.op)
                OP_JMP: uaddr_d = bus.branch_addr;
                OP_CJMP: begin
                    if (cond) uaddr_d = bus.branch_addr;
                end
                OP_CALL, OP_CCALL: begin
                    if (bus.op == OP_CALL || cond) begin
                        push    = 1'b1;
                        uaddr_d = bus.branch_addr;
                        if (stk_full) ovf_d = 1'b1;
                    end
                end
                OP_RET, OP_CRET: begin
                    if (bus.op == OP_RET || cond) begin
                        pop = 1'b1;
                        if (stk_empty) unf_d = 1'b1;
                        else           uaddr_d = stk_top;
                    end
                end
                OP_LDCNT: cnt_d = bus.branch_addr[CNT_W-1:0];
                OP_LOOP: begin
                    if (cnt_nz) begin
                        cnt_d   = cnt_q - CNT_ONE;
                        uaddr_d = bus.branch_addr;
                    end
                end
                OP_CASE: uaddr_d = {bus.branch_addr[ADDR_W-1:4],
                                    bus.branch_addr[3:0] | bus.case_bits};
                OP_PUSH: begin
                    push = 1'b1;
                    if (stk_full) ovf_d = 1'b1;
                end
                OP_RPT: begin
                    // Repeat back to the loop head left on the stack by PUSH;
                    // the head is popped only when the count is exhausted.
                    if (cnt_nz) begin
                        cnt_d = cnt_q - CNT_ONE;
                        if (stk_empty) unf_d = 1'b1;
                        else           uaddr_d = stk_top;
                    end else begin
                        pop = 1'b1;
                        if (stk_empty) unf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        addr_d = uaddr_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            start_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.uaddr     = uaddr_d;
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
    assign bus.cnt_zero  = !cnt_nz;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed self-checking bench for micro_sequencer

module tb_micro_sequencer;
    import micro_seq_pkg::*;

    typedef struct packed {
        logic [3:0]  op;
        logic [10:0] ba;
        logic [3:0]  cb;
        logic [2:0]  sel;
        logic        pol;
        logic        hold;
        logic [10:0] ua;
        logic        ovf;
        logic        unf;
        logic        cz;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    micro_sequencer_if #(.ADDR_W(11), .COND_W(8)) bus ();

    micro_sequencer #(
        .ADDR_W      (11),
        .STACK_DEPTH (4),
        .COND_W      (8),
        .CNT_W       (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply(input vec_t v);
        bus.op          = v.op;
        bus.branch_addr = v.ba;
        bus.case_bits   = v.cb;
        bus.cond_sel    = v.sel;
        bus.cond_pol    = v.pol;
        bus.hold        = v.hold;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        apply('0);
        bus.cond_in = 8'h00;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        vec_t t [4] = '{
            '{OP_CONT, 11'h0, 4'h0, 3'd0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1},
            '{OP_CONT, 11'h0, 4'h0, 3'd0, 1'b0, 1'b0, 11'h001, 1'b0, 1'b0, 1'b1},
            '{OP_CONT, 11'h0, 4'h0, 3'd0, 1'b0, 1'b0, 11'h002, 1'b0, 1'b0, 1'b1},
            '{OP_CONT, 11'h0, 4'h0, 3'd0, 1'b0, 1'b0, 11'h003, 1'b0, 1'b0, 1'b1}
        };
        reset = 1'b1;
        bus.cond_in = 8'h00;
        apply('{OP_JMP, 11'h555, 4'h0, 3'd0, 1'b0, 1'b0, 11'h0, 1'b0, 1'b0, 1'b0});
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {11'h000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=000 ovf=0 unf=0 cz=1",
                     bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(t[i]);
            @(negedge clock);
            checks++;
            if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {t[i].ua, t[i].ovf, t[i].unf, t[i].cz}) begin
                errors++;
                $display("FAIL release step %0d: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=%h ovf=%b unf=%b cz=%b",
                         i, bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero, t[i].ua, t[i].ovf, t[i].unf, t[i].cz);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_call_ret();
        vec_t t [6] = '{
            '{OP_JMP,  11'h010, 4'h0, 3'd0, 1'b0, 1'b0, 11'h010, 1'b0, 1'b0, 1'b1},
            '{OP_CALL, 11'h200, 4'h0, 3'd0, 1'b0, 1'b0, 11'h200, 1'b0, 1'b0, 1'b1},
            '{OP_CONT, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h201, 1'b0, 1'b0, 1'b1},
            '{OP_RET,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h011, 1'b0, 1'b0, 1'b1},
            '{OP_RET,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h012, 1'b0, 1'b0, 1'b1},
            '{OP_CONT, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h013, 1'b0, 1'b1, 1'b1}
        };
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            apply(t[i]);
            @(negedge clock);
            checks++;
            if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {t[i].ua, t[i].ovf, t[i].unf, t[i].cz}) begin
                errors++;
                $display("FAIL call_ret step %0d: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=%h ovf=%b unf=%b cz=%b",
                         i, bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero, t[i].ua, t[i].ovf, t[i].unf, t[i].cz);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_loop();
        vec_t t [8] = '{
            '{OP_JMP,   11'h03F, 4'h0, 3'd0, 1'b0, 1'b0, 11'h03F, 1'b0, 1'b0, 1'b1},
            '{OP_LDCNT, 11'h003, 4'h0, 3'd0, 1'b0, 1'b0, 11'h040, 1'b0, 1'b0, 1'b1},
            '{OP_LOOP,  11'h040, 4'h0, 3'd0, 1'b0, 1'b0, 11'h040, 1'b0, 1'b0, 1'b0},
            '{OP_LOOP,  11'h040, 4'h0, 3'd0, 1'b0, 1'b0, 11'h040, 1'b0, 1'b0, 1'b0},
            '{OP_LOOP,  11'h040, 4'h0, 3'd0, 1'b0, 1'b0, 11'h040, 1'b0, 1'b0, 1'b0},
            '{OP_LOOP,  11'h040, 4'h0, 3'd0, 1'b0, 1'b0, 11'h041, 1'b0, 1'b0, 1'b1},
            '{OP_LOOP,  11'h040, 4'h0, 3'd0, 1'b0, 1'b0, 11'h042, 1'b0, 1'b0, 1'b1},
            '{OP_CONT,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h043, 1'b0, 1'b0, 1'b1}
        };
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            apply(t[i]);
            @(negedge clock);
            checks++;
            if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {t[i].ua, t[i].ovf, t[i].unf, t[i].cz}) begin
                errors++;
                $display("FAIL loop step %0d: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=%h ovf=%b unf=%b cz=%b",
                         i, bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero, t[i].ua, t[i].ovf, t[i].unf, t[i].cz);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_case_cond();
        vec_t t [11] = '{
            '{OP_CASE,  11'h120, 4'h5, 3'd0, 1'b0, 1'b0, 11'h125, 1'b0, 1'b0, 1'b1},
            '{OP_CJMP,  11'h300, 4'h0, 3'd2, 1'b1, 1'b0, 11'h126, 1'b0, 1'b0, 1'b1},
            '{OP_CJMP,  11'h300, 4'h0, 3'd2, 1'b0, 1'b0, 11'h300, 1'b0, 1'b0, 1'b1},
            '{OP_CJMP,  11'h050, 4'h0, 3'd3, 1'b0, 1'b0, 11'h301, 1'b0, 1'b0, 1'b1},
            '{OP_CCALL, 11'h070, 4'h0, 3'd3, 1'b0, 1'b0, 11'h302, 1'b0, 1'b0, 1'b1},
            '{OP_CCALL, 11'h070, 4'h0, 3'd3, 1'b1, 1'b0, 11'h070, 1'b0, 1'b0, 1'b1},
            '{OP_CRET,  11'h000, 4'h0, 3'd2, 1'b1, 1'b0, 11'h071, 1'b0, 1'b0, 1'b1},
            '{OP_CRET,  11'h000, 4'h0, 3'd2, 1'b0, 1'b0, 11'h303, 1'b0, 1'b0, 1'b1},
            '{OP_CASE,  11'h12A, 4'h5, 3'd0, 1'b0, 1'b0, 11'h12F, 1'b0, 1'b0, 1'b1},
            '{4'd13,    11'h7FF, 4'h0, 3'd0, 1'b0, 1'b0, 11'h130, 1'b0, 1'b0, 1'b1},
            '{OP_CONT,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h131, 1'b0, 1'b0, 1'b1}
        };
        reset_dut();
        bus.cond_in = 8'b0000_0100;
        for (int i = 0; i < 11; i++) begin
            apply(t[i]);
            @(negedge clock);
            checks++;
            if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {t[i].ua, t[i].ovf, t[i].unf, t[i].cz}) begin
                errors++;
                $display("FAIL case_cond step %0d: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=%h ovf=%b unf=%b cz=%b",
                         i, bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero, t[i].ua, t[i].ovf, t[i].unf, t[i].cz);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_overflow();
        vec_t t [12] = '{
            '{OP_JMP,  11'h010, 4'h0, 3'd0, 1'b0, 1'b0, 11'h010, 1'b0, 1'b0, 1'b1},
            '{OP_CALL, 11'h100, 4'h0, 3'd0, 1'b0, 1'b0, 11'h100, 1'b0, 1'b0, 1'b1},
            '{OP_CALL, 11'h200, 4'h0, 3'd0, 1'b0, 1'b0, 11'h200, 1'b0, 1'b0, 1'b1},
            '{OP_CALL, 11'h300, 4'h0, 3'd0, 1'b0, 1'b0, 11'h300, 1'b0, 1'b0, 1'b1},
            '{OP_CALL, 11'h400, 4'h0, 3'd0, 1'b0, 1'b0, 11'h400, 1'b0, 1'b0, 1'b1},
            '{OP_CALL, 11'h500, 4'h0, 3'd0, 1'b0, 1'b0, 11'h500, 1'b0, 1'b0, 1'b1},
            '{OP_RET,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h301, 1'b1, 1'b0, 1'b1},
            '{OP_RET,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h201, 1'b1, 1'b0, 1'b1},
            '{OP_RET,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h101, 1'b1, 1'b0, 1'b1},
            '{OP_RET,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h011, 1'b1, 1'b0, 1'b1},
            '{OP_RET,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h012, 1'b1, 1'b0, 1'b1},
            '{OP_CONT, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h013, 1'b1, 1'b1, 1'b1}
        };
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            apply(t[i]);
            @(negedge clock);
            checks++;
            if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {t[i].ua, t[i].ovf, t[i].unf, t[i].cz}) begin
                errors++;
                $display("FAIL overflow step %0d: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=%h ovf=%b unf=%b cz=%b",
                         i, bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero, t[i].ua, t[i].ovf, t[i].unf, t[i].cz);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_hold();
        vec_t t [8] = '{
            '{OP_JMP,   11'h010, 4'h0, 3'd0, 1'b0, 1'b0, 11'h010, 1'b0, 1'b0, 1'b1},
            '{OP_CALL,  11'h200, 4'h0, 3'd0, 1'b0, 1'b1, 11'h010, 1'b0, 1'b0, 1'b1},
            '{OP_CALL,  11'h200, 4'h0, 3'd0, 1'b0, 1'b1, 11'h010, 1'b0, 1'b0, 1'b1},
            '{OP_CALL,  11'h200, 4'h0, 3'd0, 1'b0, 1'b0, 11'h200, 1'b0, 1'b0, 1'b1},
            '{OP_RET,   11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h011, 1'b0, 1'b0, 1'b1},
            '{OP_RET,   11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h012, 1'b0, 1'b0, 1'b1},
            '{OP_LDCNT, 11'h005, 4'h0, 3'd0, 1'b0, 1'b1, 11'h012, 1'b0, 1'b1, 1'b1},
            '{OP_CONT,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h013, 1'b0, 1'b1, 1'b1}
        };
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            apply(t[i]);
            @(negedge clock);
            checks++;
            if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {t[i].ua, t[i].ovf, t[i].unf, t[i].cz}) begin
                errors++;
                $display("FAIL hold step %0d: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=%h ovf=%b unf=%b cz=%b",
                         i, bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero, t[i].ua, t[i].ovf, t[i].unf, t[i].cz);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_rpt();
        vec_t t [10] = '{
            '{OP_LDCNT, 11'h002, 4'h0, 3'd0, 1'b0, 1'b0, 11'h001, 1'b0, 1'b0, 1'b1},
            '{OP_PUSH,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h002, 1'b0, 1'b0, 1'b0},
            '{OP_CONT,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h003, 1'b0, 1'b0, 1'b0},
            '{OP_RPT,   11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h002, 1'b0, 1'b0, 1'b0},
            '{OP_CONT,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h003, 1'b0, 1'b0, 1'b0},
            '{OP_RPT,   11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h002, 1'b0, 1'b0, 1'b0},
            '{OP_CONT,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h003, 1'b0, 1'b0, 1'b1},
            '{OP_RPT,   11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h004, 1'b0, 1'b0, 1'b1},
            '{OP_RET,   11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h005, 1'b0, 1'b0, 1'b1},
            '{OP_CONT,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h006, 1'b0, 1'b1, 1'b1}
        };
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            apply(t[i]);
            @(negedge clock);
            checks++;
            if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {t[i].ua, t[i].ovf, t[i].unf, t[i].cz}) begin
                errors++;
                $display("FAIL rpt step %0d: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=%h ovf=%b unf=%b cz=%b",
                         i, bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero, t[i].ua, t[i].ovf, t[i].unf, t[i].cz);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_mid();
        vec_t t [4] = '{
            '{OP_CONT,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1},
            '{OP_LDCNT, 11'h001, 4'h0, 3'd0, 1'b0, 1'b0, 11'h001, 1'b0, 1'b0, 1'b1},
            '{OP_RPT,   11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h002, 1'b0, 1'b0, 1'b0},
            '{OP_CONT,  11'h000, 4'h0, 3'd0, 1'b0, 1'b0, 11'h003, 1'b0, 1'b1, 1'b1}
        };
        reset_dut();
        apply('{OP_CALL, 11'h100, 4'h0, 3'd0, 1'b0, 1'b0, 11'h0, 1'b0, 1'b0, 1'b0});
        @(posedge clock); #1;
        apply('{OP_CALL, 11'h200, 4'h0, 3'd0, 1'b0, 1'b0, 11'h0, 1'b0, 1'b0, 1'b0});
        @(posedge clock); #1;
        apply('{OP_LDCNT, 11'h007, 4'h0, 3'd0, 1'b0, 1'b0, 11'h0, 1'b0, 1'b0, 1'b0});
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {11'h000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_state: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=000 ovf=0 unf=0 cz=1",
                     bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(t[i]);
            @(negedge clock);
            checks++;
            if ({bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero} !== {t[i].ua, t[i].ovf, t[i].unf, t[i].cz}) begin
                errors++;
                $display("FAIL reset_mid step %0d: uaddr=%h ovf=%b unf=%b cz=%b expected uaddr=%h ovf=%b unf=%b cz=%b",
                         i, bus.uaddr, bus.stack_ovf, bus.stack_unf, bus.cnt_zero, t[i].ua, t[i].ovf, t[i].unf, t[i].cz);
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.cond_in = 8'h00;
        apply('0);
        test_reset();
        test_call_ret();
        test_loop();
        test_case_cond();
        test_overflow();
        test_hold();
        test_rpt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
